// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI link types and constants
package spi_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   // {CKP, CPH}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   localparam int          DEFAULT_WIDTH = 16;
   localparam logic [15:0] RESET_WORD    = 16'h0605;

   function automatic logic sample_on_rise(input logic [1:0] mode);
      return mode[1] == mode[0];
   endfunction

endpackage

// File: rtl/spi_rx_slave_if.sv
// rtl/spi_rx_slave_if.sv - link and parallel-side signals of the SPI receiver
interface spi_rx_slave_if
   import spi_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             CKP;
   logic             CPH;
   logic             SCK;
   logic             CS;
   logic             MOSI;
   logic [WIDTH-1:0] TX_DATA;
   logic             MISO;
   logic [WIDTH-1:0] RX_DATA;
   logic             RX_VALID;
   logic             RX_ACK;
   logic             OVERRUN;
   logic             ABORT;
   logic             BUSY;

   modport slave (
      input  CKP, CPH, SCK, CS, MOSI, TX_DATA, RX_ACK,
      output MISO, RX_DATA, RX_VALID, OVERRUN, ABORT, BUSY
   );

   modport master (
      output CKP, CPH, SCK, CS, MOSI, TX_DATA, RX_ACK,
      input  MISO, RX_DATA, RX_VALID, OVERRUN, ABORT, BUSY
   );
endinterface

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - single-bit multi-flop synchronizer with selectable reset value
module spi_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);
   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= {STAGES{RESET_VAL}};
      end else begin
         r_sync[0] <= i_d;
         for (int i = 1; i < STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/spi_rx_slave.sv
// rtl/spi_rx_slave.sv - oversampling SPI slave: MSB-first word receiver with parallel reply on MISO
module spi_rx_slave
   import spi_pkg::*;
#(
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic          CLK,
   input  logic          RESET,
   spi_rx_slave_if.slave bus
);
   localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   logic w_sck_s;
   logic w_cs_s;
   logic w_mosi_s;

   // MOSI shares the SCK depth so data and clock stay aligned after sync
   spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
      .i_clk(CLK), .i_rst(RESET), .i_d(bus.SCK), .o_q(w_sck_s)
   );
   spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .i_clk(CLK), .i_rst(RESET), .i_d(bus.CS), .o_q(w_cs_s)
   );
   spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .i_clk(CLK), .i_rst(RESET), .i_d(bus.MOSI), .o_q(w_mosi_s)
   );

   logic             r_sck_d;
   logic             r_cs_d;
   logic [1:0]       r_mode;
   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-2:0] r_rx_sreg;
   logic [WIDTH-1:0] r_tx_sreg;
   logic [CNT_W-1:0] r_bit_cnt;
   logic             r_first_sample;
   logic             r_reload;
   logic [WIDTH-1:0] r_rx_data;
   logic             r_rx_valid;
   logic             r_overrun;
   logic             r_abort;

   logic             w_sck_rise;
   logic             w_sck_fall;
   logic             w_cs_fall;
   logic             w_cs_rise;
   logic             w_sample_edge;
   logic             w_shift_edge;
   logic [WIDTH-1:0] w_rx_word;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_sck_d <= 1'b0;
         r_cs_d  <= 1'b1;
      end else begin
         r_sck_d <= w_sck_s;
         r_cs_d  <= w_cs_s;
      end
   end

   assign w_sck_rise    = w_sck_s & ~r_sck_d;
   assign w_sck_fall    = ~w_sck_s & r_sck_d;
   assign w_cs_fall     = ~w_cs_s & r_cs_d;
   assign w_cs_rise     = w_cs_s & ~r_cs_d;
   assign w_sample_edge = sample_on_rise(r_mode) ? w_sck_rise : w_sck_fall;
   assign w_shift_edge  = sample_on_rise(r_mode) ? w_sck_fall : w_sck_rise;
   assign w_rx_word     = {r_rx_sreg, w_mosi_s};

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:   if (w_cs_fall) w_next_state = ST_ACTIVE;
         ST_ACTIVE: if (w_cs_rise) w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.BUSY = 1'b0;
      bus.MISO = 1'b0;
      if (r_state == ST_ACTIVE) begin
         bus.BUSY = 1'b1;
         bus.MISO = r_tx_sreg[WIDTH-1];
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_mode         <= MODE0;
         r_rx_sreg      <= '0;
         r_tx_sreg      <= '0;
         r_bit_cnt      <= '0;
         r_first_sample <= 1'b0;
         r_reload       <= 1'b0;
         r_rx_data      <= '0;
         r_rx_valid     <= 1'b0;
         r_overrun      <= 1'b0;
         r_abort        <= 1'b0;
      end else begin
         r_abort <= 1'b0;
         if (bus.RX_ACK) r_rx_valid <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_cs_fall) begin
                  r_mode         <= {bus.CKP, bus.CPH};
                  r_tx_sreg      <= bus.TX_DATA;
                  r_bit_cnt      <= '0;
                  r_first_sample <= 1'b0;
                  r_reload       <= 1'b0;
               end
            end
            ST_ACTIVE: begin
               if (w_cs_rise) begin
                  r_abort   <= (r_bit_cnt != '0);
                  r_bit_cnt <= '0;
               end else begin
                  if (w_sample_edge) begin
                     r_rx_sreg      <= w_rx_word[WIDTH-2:0];
                     r_first_sample <= 1'b1;
                     if (r_bit_cnt == LAST_BIT) begin
                        // a same-cycle ack consumes the old word, so no overrun
                        r_rx_data  <= w_rx_word;
                        r_rx_valid <= 1'b1;
                        if (r_rx_valid && !bus.RX_ACK) r_overrun <= 1'b1;
                        r_bit_cnt  <= '0;
                        r_reload   <= 1'b1;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                     end
                  end
                  if (w_shift_edge && r_first_sample) begin
                     if (r_reload) begin
                        r_tx_sreg <= bus.TX_DATA;
                        r_reload  <= 1'b0;
                     end else begin
                        r_tx_sreg <= {r_tx_sreg[WIDTH-2:0], 1'b0};
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.RX_DATA  = r_rx_data;
   assign bus.RX_VALID = r_rx_valid;
   assign bus.OVERRUN  = r_overrun;
   assign bus.ABORT    = r_abort;
endmodule
